// File: rtl/alu_mc_pkg.sv
// -----------------------------------------------------------------------------
// alu_mc_pkg
// Shared definitions for the multi-cycle ALU (alu_mc) and its iterative
// multiply/divide engine (muldiv_iter):
//   - opcode constants (4-bit encodings)
//   - FSM state type
//   - is_iterative(): true for opcodes that need the multi-cycle engine
// Optional feature macro: ALU_MC_MULDIV_EN (consumed by alu_mc).
// -----------------------------------------------------------------------------
package alu_mc_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_MULHU = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_EQ    = 4'b1000;
    localparam logic [3:0] OP_DIV   = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_REM   = 4'b1011;
    localparam logic [3:0] OP_SLT   = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;
    localparam logic [3:0] OP_SLTU  = 4'b1110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_iterative(input logic [3:0] op);
        case (op)
            OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_mc_muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
// Bit-serial engine: shift-add multiplier and restoring divider, one result
// bit per clock.  Operands are captured on start; DATA_WIDTH steps follow.
// done is asserted during the final step and result carries the value that
// the final step produces, so the parent can register it on that same edge.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   start       load operands/opcode and begin (ignored while abort is high)
//   abort       drop any operation in progress
//   op          opcode (MUL, MULHU, DIV, DIVU, REM, REMU)
//   src_a/src_b operands (dividend/divisor for division)
//   done        final step is happening this cycle
//   result      finished result, valid while done is high
// -----------------------------------------------------------------------------
module muldiv_iter
    import alu_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [3:0]       op_q;
    logic [W-1:0]     hi_q;
    logic [W-1:0]     lo_q;
    logic [W-1:0]     m_q;
    logic             neg_q;
    logic             neg_r;
    logic             busy;
    logic [CNT_W-1:0] cnt;

    logic             mul_op;
    logic             start_signed;
    logic             a_neg;
    logic             b_neg;
    logic [W:0]       mul_sum;
    logic [W:0]       div_shift;
    logic [W:0]       div_diff;
    logic             div_take;
    logic [W-1:0]     hi_n;
    logic [W-1:0]     lo_n;

    assign mul_op       = (op_q == OP_MUL) || (op_q == OP_MULHU);
    assign start_signed = (op == OP_DIV) || (op == OP_REM);
    assign a_neg        = start_signed & src_a[W-1];
    assign b_neg        = start_signed & src_b[W-1];
    assign done         = busy && (cnt == CNT_W'(W - 1));

    // Multiply: {hi,lo} starts as {0, multiplier}; each step adds the
    // multiplicand into hi when lo[0] is set and shifts the pair right.
    // Divide: {hi,lo} starts as {0, |dividend|}; each step shifts one
    // dividend bit into hi, subtracts |divisor| if it fits and shifts the
    // quotient bit into lo.  A zero divisor forces every subtraction to
    // "fit", which naturally yields an all-ones quotient and a remainder
    // equal to the dividend magnitude.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        div_shift = {hi_q, lo_q[W-1]};
        div_diff  = div_shift - {1'b0, m_q};
        div_take  = ~div_diff[W] | (m_q == '0);
        if (mul_op) begin
            hi_n = mul_sum[W:1];
            lo_n = {mul_sum[0], lo_q[W-1:1]};
        end else begin
            hi_n = div_take ? div_diff[W-1:0] : div_shift[W-1:0];
            lo_n = {lo_q[W-2:0], div_take};
        end
    end

    // Signed results are restored from the unsigned magnitudes: the quotient
    // is negated when operand signs differ, the remainder follows the dividend.
    always_comb begin
        result = '0;
        case (op_q)
            OP_MUL:           result = lo_n;
            OP_MULHU:         result = hi_n;
            OP_DIV, OP_DIVU:  result = neg_q ? -lo_n : lo_n;
            OP_REM, OP_REMU:  result = neg_r ? -hi_n : hi_n;
            default:          result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            busy  <= 1'b0;
            cnt   <= '0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            op_q <= op;
            busy <= 1'b1;
            cnt  <= '0;
            hi_q <= '0;
            if ((op == OP_MUL) || (op == OP_MULHU)) begin
                lo_q  <= src_b;
                m_q   <= src_a;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end else begin
                lo_q  <= a_neg ? -src_a : src_a;
                m_q   <= b_neg ? -src_b : src_b;
                // Divide-by-zero keeps the all-ones quotient unsigned.
                neg_q <= (a_neg ^ b_neg) && (src_b != '0);
                neg_r <= a_neg;
            end
        end else if (busy) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
            cnt  <= cnt + CNT_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
// Multi-cycle ALU with valid/ready handshakes on both sides.  Single-cycle
// ops complete the cycle after accept; iterative ops (multiply/divide) run
// through muldiv_iter and complete DATA_WIDTH+1 cycles after accept.
// Optional feature macro: ALU_MC_MULDIV_EN.  When undefined the iterative
// opcodes behave as unlisted opcodes (result 0, single cycle) and neither the
// CALC path nor the iterative datapath is built.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  operation handshake (in_ready only in IDLE)
//   SrcA, SrcB           operands, captured at accept
//   Operation            opcode, captured at accept
//   flush                abort in-flight work; returns to IDLE next cycle
//   out_valid/out_ready  result handshake
//   ALUResult            registered result, held while out_valid waits
// -----------------------------------------------------------------------------
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult
);

    state_t                state_q;
    state_t                state_d;
    logic                  accept;
    logic [3:0]            op_low;
    logic                  op_high_zero;
    logic [DATA_WIDTH-1:0] single_result;
    logic [DATA_WIDTH-1:0] result_d;
    logic                  load_result;

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign accept       = in_valid && in_ready && !flush;
    // Opcodes wider than 4 bits are only recognised when the extra bits are 0.
    assign op_low       = Operation[3:0];
    assign op_high_zero = ((Operation >> 4) == '0);

    always_comb begin
        single_result = '0;
        if (op_high_zero) begin
            case (op_low)
                OP_AND:  single_result = SrcA & SrcB;
                OP_OR:   single_result = SrcA | SrcB;
                OP_XOR:  single_result = SrcA ^ SrcB;
                OP_ADD:  single_result = SrcA + SrcB;
                OP_SUB:  single_result = SrcA - SrcB;
                OP_EQ:   single_result = DATA_WIDTH'(SrcA == SrcB);
                OP_SLT:  single_result = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
                OP_SLTU: single_result = DATA_WIDTH'(SrcA < SrcB);
                default: single_result = '0;
            endcase
        end
    end

`ifdef ALU_MC_MULDIV_EN
    logic                  start_iter;
    logic                  md_done;
    logic [DATA_WIDTH-1:0] md_result;

    assign start_iter = accept && op_high_zero && is_iterative(op_low);

    muldiv_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_iter),
        .abort  (flush),
        .op     (op_low),
        .src_a  (SrcA),
        .src_b  (SrcB),
        .done   (md_done),
        .result (md_result)
    );
`endif

    // Flush overrides everything else, so neither an accept nor a result
    // load can happen in a flush cycle.
    always_comb begin
        state_d     = state_q;
        load_result = 1'b0;
        result_d    = single_result;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
`ifdef ALU_MC_MULDIV_EN
                        if (start_iter) begin
                            state_d = CALC;
                        end else begin
                            state_d     = DONE;
                            load_result = 1'b1;
                        end
`else
                        state_d     = DONE;
                        load_result = 1'b1;
`endif
                    end
                end
`ifdef ALU_MC_MULDIV_EN
                CALC: begin
                    if (md_done) begin
                        state_d     = DONE;
                        load_result = 1'b1;
                        result_d    = md_result;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ALUResult <= '0;
        end else begin
            state_q <= state_d;
            if (load_result) begin
                ALUResult <= result_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc
// Directed self-checking bench for alu_mc (DATA_WIDTH = 32).  Expected
// results are pushed to a scoreboard when an operation is driven and popped
// when the DUT presents its result.  Iterative-op checks are built only when
// ALU_MC_MULDIV_EN is defined; otherwise those opcodes are checked as
// unlisted opcodes.
// -----------------------------------------------------------------------------
module tb_alu_mc;

    localparam int W = 32;

    localparam logic [3:0] C_AND   = 4'b0000;
    localparam logic [3:0] C_OR    = 4'b0001;
    localparam logic [3:0] C_ADD   = 4'b0010;
    localparam logic [3:0] C_XOR   = 4'b0011;
    localparam logic [3:0] C_MUL   = 4'b0100;
    localparam logic [3:0] C_MULHU = 4'b0101;
    localparam logic [3:0] C_SUB   = 4'b0110;
    localparam logic [3:0] C_BAD   = 4'b0111;
    localparam logic [3:0] C_EQ    = 4'b1000;
    localparam logic [3:0] C_DIV   = 4'b1001;
    localparam logic [3:0] C_DIVU  = 4'b1010;
    localparam logic [3:0] C_REM   = 4'b1011;
    localparam logic [3:0] C_SLT   = 4'b1100;
    localparam logic [3:0] C_REMU  = 4'b1101;
    localparam logic [3:0] C_SLTU  = 4'b1110;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic [3:0]   Operation;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALUResult;

    int           tests = 0;
    int           fails = 0;
    logic [31:0]  exp_q[$];
    int           lat_q[$];

    always #5 clk = ~clk;

    alu_mc #(
        .DATA_WIDTH    (W),
        .OPCODE_LENGTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Operation (Operation),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Called at a negedge with the DUT idle; returns 1 ns after the accept edge
    // with the operand inputs scrambled to prove they were captured.
    task automatic applyStimulus(input string tag, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp, input int lat);
        checkOutput({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        SrcA      = a;
        SrcB      = b;
        Operation = op;
        in_valid  = 1'b1;
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        SrcA      = $urandom;
        SrcB      = $urandom;
        Operation = 4'($urandom);
    endtask

    task automatic waitResult(input string tag, input int hold);
        int          cyc;
        logic [31:0] exp;
        int          lat;
        cyc = 0;
        exp = exp_q.pop_front();
        lat = lat_q.pop_front();
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 200);
        checkOutput({tag, " latency"}, 32'(cyc), 32'(lat));
        checkOutput(tag, ALUResult, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({tag, " held out_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, " held result"}, ALUResult, exp);
            checkOutput({tag, " held in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, " in_ready after pop"}, 32'(in_ready), 32'd1);
        checkOutput({tag, " out_valid after pop"}, 32'(out_valid), 32'd0);
    endtask

    task automatic runOp(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        applyStimulus(tag, op, a, b, exp, lat);
        waitResult(tag, 0);
    endtask

    initial begin
        int seen;
`ifdef ALU_MC_MULDIV_EN
        int iter_lat;
        iter_lat = W + 1;
`endif
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        SrcA      = '0;
        SrcB      = '0;
        Operation = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset ALUResult", ALUResult, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready after reset", 32'(in_ready), 32'd1);

        // Single-cycle operations.
        runOp("SLT -1<1", C_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        runOp("SLTU max<1", C_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        runOp("SLT 5<-3", C_SLT, 32'd5, 32'hFFFF_FFFD, 32'd0, 1);
        runOp("SLTU 5<fffffffd", C_SLTU, 32'd5, 32'hFFFF_FFFD, 32'd1, 1);
        runOp("AND", C_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
        runOp("OR", C_OR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1);
        runOp("XOR", C_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1);
        runOp("SUB 5-7", C_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
        runOp("ADD wrap", C_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1, 1);
        runOp("EQ equal", C_EQ, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd1, 1);
        runOp("EQ differ", C_EQ, 32'hDEAD_BEEF, 32'hDEAD_BEEE, 32'd0, 1);
        runOp("unlisted 0111", C_BAD, 32'h1234_5678, 32'h1, 32'd0, 1);

        // Backpressure: result held while out_ready stays low.
        applyStimulus("ADD 3+4 held", C_ADD, 32'd3, 32'd4, 32'd7, 1);
        waitResult("ADD 3+4 held", 3);
        runOp("ADD after hold", C_ADD, 32'd10, 32'd20, 32'd30, 1);

        // Flush in DONE drops the pending result.
        applyStimulus("flush DONE", C_AND, 32'hFF, 32'h0F, 32'h0F, 1);
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        @(negedge clk);
        checkOutput("flush DONE pre out_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("flush DONE out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush DONE in_ready", 32'(in_ready), 32'd1);

        // A valid request presented during flush must not be accepted.
        SrcA = 32'd2;
        SrcB = 32'd2;
        Operation = C_ADD;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush blocks accept out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush blocks accept in_ready", 32'(in_ready), 32'd1);

        // Reset while a result waits in DONE.
        applyStimulus("reset DONE", C_ADD, 32'd5, 32'd6, 32'd11, 1);
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        @(negedge clk);
        checkOutput("reset DONE pre result", ALUResult, 32'd11);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset DONE out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset DONE ALUResult", ALUResult, 32'd0);
        @(negedge clk);
        checkOutput("reset DONE in_ready", 32'(in_ready), 32'd1);

`ifdef ALU_MC_MULDIV_EN
        runOp("MUL 7*-3", C_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, iter_lat);
        runOp("MULHU max*max", C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, iter_lat);
        runOp("MUL 2*3", C_MUL, 32'd2, 32'd3, 32'd6, iter_lat);
        runOp("DIV ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, iter_lat);
        runOp("REM ovf", C_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, iter_lat);
        runOp("DIVU 5/0", C_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, iter_lat);
        runOp("REMU 5/0", C_REMU, 32'd5, 32'd0, 32'd5, iter_lat);
        runOp("DIV -7/0", C_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, iter_lat);
        runOp("REM -7/0", C_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, iter_lat);
        runOp("DIV -7/2", C_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, iter_lat);
        runOp("REM -7/2", C_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, iter_lat);
        runOp("DIV 7/-2", C_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, iter_lat);
        runOp("DIVU 100/7", C_DIVU, 32'd100, 32'd7, 32'd14, iter_lat);
        runOp("REMU 100/7", C_REMU, 32'd100, 32'd7, 32'd2, iter_lat);

        // Flush at cycle 10 of a DIVU.
        applyStimulus("flush DIVU", C_DIVU, 32'd100, 32'd7, 32'd14, iter_lat);
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        seen = 0;
        repeat (9) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush DIVU early out_valid", 32'(seen), 32'd0);
        checkOutput("flush DIVU out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush DIVU in_ready", 32'(in_ready), 32'd1);
        runOp("ADD 1+1 after flush", C_ADD, 32'd1, 32'd1, 32'd2, 1);

        // Reset for one cycle in the middle of a MUL.
        applyStimulus("reset MUL", C_MUL, 32'd9, 32'd9, 32'd81, iter_lat);
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset MUL out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset MUL ALUResult", ALUResult, 32'd0);
        @(negedge clk);
        checkOutput("reset MUL in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("reset MUL no late result", 32'(seen), 32'd0);
`else
        runOp("MUL 2*3 disabled", C_MUL, 32'd2, 32'd3, 32'd0, 1);
        runOp("MULHU disabled", C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1);
        runOp("DIVU 5/0 disabled", C_DIVU, 32'd5, 32'd0, 32'd0, 1);
        runOp("REM disabled", C_REM, 32'd7, 32'd2, 32'd0, 1);
        runOp("REMU disabled", C_REMU, 32'd7, 32'd2, 32'd0, 1);
        runOp("DIV disabled", C_DIV, 32'd7, 32'd2, 32'd0, 1);
        seen = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter OPCODE_LENGTH, default 4, width of Operation.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  operands and Operation are presented.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 SrcA  input  DATA_WIDTH  first operand.
REQ-008 SrcB  input  DATA_WIDTH  second operand.
REQ-009 Operation  input  OPCODE_LENGTH  operation code.
REQ-010 flush  input  1  abort any in-flight operation.
REQ-011 out_valid  output  1  ALUResult is valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 ALUResult  output  DATA_WIDTH  registered result.

Function
REQ-014 Accept occurs when in_valid && in_ready; in_ready SHALL be 1 only in IDLE.
REQ-015 FSM states IDLE, CALC, DONE; IDLE->DONE on accepting a single-cycle op; IDLE->CALC on accepting an iterative op; CALC->DONE when iteration count reaches DATA_WIDTH; DONE->IDLE when out_ready=1.
REQ-016 Single-cycle ops: 0000 AND, 0001 OR, 0011 XOR, 0010 ADD, 0110 SUB, 1000 EQ (1/0), 1100 SLT signed (1/0), 1110 SLTU unsigned (1/0); out_valid SHALL rise the cycle after accept.
REQ-017 Iterative ops: 0100 MUL (low DATA_WIDTH bits of product), 0101 MULHU (high bits, unsigned), 1001 DIV, 1010 DIVU, 1011 REM, 1101 REMU; one result bit per cycle; out_valid SHALL rise exactly DATA_WIDTH+1 cycles after accept.
REQ-018 Signed DIV/REM SHALL truncate toward zero; remainder takes the sign of the dividend.
REQ-019 Divide by zero: DIV/DIVU result all ones, REM/REMU result = SrcA; latency unchanged.
REQ-020 Signed overflow (most-negative / -1): DIV result = SrcA, REM result = 0.
REQ-021 Unlisted opcode: result 0, single-cycle latency.
REQ-022 Operands and Operation SHALL be captured at accept; later input changes have no effect.
REQ-023 In DONE, out_valid and ALUResult SHALL hold stable until out_ready=1.
REQ-024 flush SHALL force IDLE next cycle with out_valid=0, in any state; flush has priority over out_ready and in_valid; no accept in a flush cycle.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, out_valid=0, ALUResult=0, counter=0; in_ready=1 from the first cycle after reset releases.
REQ-026 Reset mid-CALC or mid-DONE SHALL discard the operation; no result is emitted.

Configuration
REQ-027 Macro ALU_MC_MULDIV_EN defined: iterative ops per REQ-017..020.
REQ-028 Macro undefined: iterative opcodes treated as unlisted (REQ-021); CALC state and iteration datapath SHALL not be synthesised.

Structure
REQ-029 Package alu_mc_pkg SHALL hold the opcode constants, the FSM state typedef and an is_iterative(op) helper function.
REQ-030 Shift-add multiplier / restoring divider SHALL be sub-module muldiv_iter (start, op, operands in; done, result out), instantiated only under ALU_MC_MULDIV_EN.

Verification (DATA_WIDTH=32)
REQ-031 SLT SrcA=0xFFFFFFFF, SrcB=1 -> ALUResult=1, out_valid 1 cycle after accept; SLTU same operands -> 0.
REQ-032 MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB at cycle 33 after accept; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
REQ-034 ADD 3+4 with out_ready held 0 for 3 cycles -> ALUResult=7, out_valid=1 stable, in_ready=0 throughout; accept of next op in the cycle after out_ready=1.
REQ-035 flush at cycle 10 of a DIVU -> no out_valid, in_ready=1 next cycle; new ADD 1+1 -> 2 after 1 cycle.
REQ-036 rst_n low 1 cycle mid-MUL -> out_valid=0, ALUResult=0, in_ready=1 after release; build without ALU_MC_MULDIV_EN: MUL 2x3 -> 0 after 1 cycle.
